// File: rtl/external_interrupt_controller_pkg.sv
// Shared definitions for the external interrupt controller.
//   - Register word offsets within the controller's 4-word I/O window.
//   - FSM state encodings of the request/acknowledge handshake.
//   - Helper that packs the STAT register word.
package external_interrupt_controller_pkg;

   localparam logic [1:0] EIC_REG_PEND = 2'd0;
   localparam logic [1:0] EIC_REG_MASK = 2'd1;
   localparam logic [1:0] EIC_REG_STAT = 2'd2;

   typedef enum logic [1:0] {
      EIC_S_IDLE = 2'd0,
      EIC_S_REQ  = 2'd1,
      EIC_S_ACKD = 2'd2
   } eic_state_t;

   // STAT layout: bit 31 = request active, bits 4:0 = current id.
   function automatic logic [31:0] eic_stat_word(input logic req, input logic [4:0] id);
      return {req, 26'b0, id};
   endfunction

endpackage

// File: rtl/external_interrupt_controller_prio_enc.sv
// eic_priority_encoder: combinational fixed-priority encoder.
// Ports:
//   vec  in   NUM_SRC  request vector
//   idx  out  ID_W     index of the lowest set bit (0 when none set)
//   any  out  1        at least one bit of vec is set
module eic_priority_encoder
   import external_interrupt_controller_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_SRC-1:0] vec,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   // Scan from the top down so the lowest set index is the final assignment.
   always_comb begin
      idx = '0;
      any = |vec;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/external_interrupt_controller.sv
// external_interrupt_controller: collects NUM_SRC interrupt lines, latches
// rising edges as pending, masks them and presents the lowest-index eligible
// source to the core through a Req/Id/Ack handshake. Memory-mapped on the
// core I/O bus (PEND w1c, MASK r/w, STAT read-only).
// Optional build macro: EIC_INPUT_SYNC_EN adds a 2-flop synchronizer per
// source ahead of the edge detector (+2 cycles of latency).
// Ports:
//   Sys_Clock   in   1        system clock, rising edge
//   Sys_Reset   in   1        asynchronous active-high reset
//   Irq_Src     in   NUM_SRC  raw interrupt lines, rising edge = event
//   EIC_I_Req   out  1        interrupt request to the core
//   EIC_I_Id    out  ID_W     id of the requested source
//   EIC_I_Ack   in   1        core acknowledge pulse
//   IO_EnR      in   1        I/O read strobe
//   IO_EnW      in   1        I/O write strobe
//   IO_Address  in   30       I/O word address
//   IO_DataW    in   32       I/O write data
//   EIC_DataR   out  32       registered read data (one cycle after the read)
module external_interrupt_controller
   import external_interrupt_controller_pkg::*;
#(
   parameter int          NUM_SRC   = 2,
   parameter int          ID_W      = 1,
   parameter logic [29:0] BASE_ADDR = 30'h3FFFFFC0
) (
   input  logic               Sys_Clock,
   input  logic               Sys_Reset,
   input  logic [NUM_SRC-1:0] Irq_Src,
   output logic               EIC_I_Req,
   output logic [ID_W-1:0]    EIC_I_Id,
   input  logic               EIC_I_Ack,
   input  logic               IO_EnR,
   input  logic               IO_EnW,
   input  logic [29:0]        IO_Address,
   input  logic [31:0]        IO_DataW,
   output logic [31:0]        EIC_DataR
);

   logic [NUM_SRC-1:0] src_s;
   logic [NUM_SRC-1:0] prev;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] clr;
   logic [ID_W-1:0]    winner;
   logic               any_elig;
   logic [29:0]        offset;
   logic               hit;
   logic [1:0]         reg_sel;
   logic               wr_pend;
   logic               wr_mask;
   logic [31:0]        rd_word;
   logic [31:0]        rdata_p1;
   eic_state_t         state;
   logic               unused_dataw;

`ifdef EIC_INPUT_SYNC_EN
   logic [NUM_SRC-1:0] sync_a;
   logic [NUM_SRC-1:0] sync_b;

   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= Irq_Src;
         sync_b <= sync_a;
      end
   end

   assign src_s = sync_b;
`else
   assign src_s = Irq_Src;
`endif

   assign rise = src_s & ~prev;

   // Window hit: subtracting the base makes the decode correct for any base
   // alignment, not only for bases that are multiples of 4.
   assign offset  = IO_Address - BASE_ADDR;
   assign hit     = (offset[29:2] == '0);
   assign reg_sel = offset[1:0];
   assign wr_pend = IO_EnW & hit & (reg_sel == EIC_REG_PEND);
   assign wr_mask = IO_EnW & hit & (reg_sel == EIC_REG_MASK);

   // Upper write-data bits beyond NUM_SRC are architecturally ignored.
   assign unused_dataw = ^IO_DataW;

   assign eligible = pending & mask;

   eic_priority_encoder #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio (
      .vec (eligible),
      .idx (winner),
      .any (any_elig)
   );

   // Acknowledge clears the bit of the id handed to the core, regardless of
   // what the mask or pending registers look like now.
   always_comb begin
      ack_clr = '0;
      if (state == EIC_S_REQ && EIC_I_Ack) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (EIC_I_Id == ID_W'(i)) ack_clr[i] = 1'b1;
         end
      end
   end

   assign clr = (wr_pend ? IO_DataW[NUM_SRC-1:0] : '0) | ack_clr;

   always_comb begin
      rd_word = '0;
      case (reg_sel)
         EIC_REG_PEND: rd_word = 32'(pending);
         EIC_REG_MASK: rd_word = 32'(mask);
         EIC_REG_STAT: rd_word = eic_stat_word(EIC_I_Req, 5'(EIC_I_Id));
         default:      rd_word = '0;
      endcase
   end

   // Edge history, pending/mask state, read data (WB stage).
   // A new edge is OR-ed in after the clear, so set wins a collision.
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         prev     <= '0;
         pending  <= '0;
         mask     <= '0;
         rdata_p1 <= '0;
      end else begin
         prev    <= src_s;
         pending <= (pending & ~clr) | rise;
         if (wr_mask) mask <= IO_DataW[NUM_SRC-1:0];
         if (IO_EnR && hit) rdata_p1 <= rd_word;
      end
   end

   assign EIC_DataR = rdata_p1;

   // Handshake FSM with registered Req/Id. ACKD forces a Req-low gap.
   always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
      if (Sys_Reset) begin
         state     <= EIC_S_IDLE;
         EIC_I_Req <= 1'b0;
         EIC_I_Id  <= '0;
      end else begin
         case (state)
            EIC_S_IDLE: begin
               if (any_elig) begin
                  state     <= EIC_S_REQ;
                  EIC_I_Req <= 1'b1;
                  EIC_I_Id  <= winner;
               end
            end
            EIC_S_REQ: begin
               if (EIC_I_Ack) begin
                  state     <= EIC_S_ACKD;
                  EIC_I_Req <= 1'b0;
               end
            end
            EIC_S_ACKD: begin
               state <= EIC_S_IDLE;
            end
            default: begin
               state     <= EIC_S_IDLE;
               EIC_I_Req <= 1'b0;
            end
         endcase
      end
   end

endmodule
